reg_mux_n: RTL and testbench
============================

REG_MUX_N -- requirements
Module: reg_mux_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each input and output.
REQ-002 SHALL have parameter N, default 3: input channel count; legal range 2..16.
REQ-003 SHALL have localparam SEL_W = max(1, ceil(log2(N))): select width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel, input, SEL_W: channel select, sampled with in_valid.
REQ-008 SHALL have port in_valid, input, 1: upstream offers in_data/sel this cycle.
REQ-009 SHALL have port in_ready, output, 1: block accepts a transfer this cycle.
REQ-010 SHALL have port out_data, output, WIDTH: registered selected data.
REQ-011 SHALL have port out_valid, output, 1: out_data holds an unconsumed result.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes out_data this cycle.
REQ-013 SHALL have port sel_err, output, 1: sticky flag; an out-of-range select was accepted.
REQ-014 SHALL have port err_cnt, output, 8: saturating count of accepted out-of-range selects.
REQ-015 SHALL have port err_clr, input, 1: synchronous clear of sel_err and err_cnt.

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally; no other path from out_ready to outputs.
REQ-017 SHALL accept a transfer when in_valid && in_ready, with one-cycle latency: out_data and out_valid update on the accepting edge.
REQ-018 SHALL load out_data with channel sel when sel < N.
REQ-019 SHALL load out_data with all-zeros when sel >= N; it SHALL never drive Z or X.
REQ-020 SHALL set out_valid=1 on accept; on out_ready without a new accept, out_valid SHALL clear to 0.
REQ-021 SHALL hold out_data and out_valid stable while out_valid && !out_ready, whatever the changes on in_data, sel or in_valid.
REQ-022 SHALL, on simultaneous consume and accept (out_valid, out_ready, in_valid), load new data with out_valid staying 1: back-to-back throughput of one per cycle.
REQ-023 SHALL increment err_cnt and set sel_err on each accepted transfer with sel >= N; non-accepted out-of-range selects SHALL be ignored.
REQ-024 SHALL saturate err_cnt at 255; further errors SHALL leave it at 255, with sel_err 1.
REQ-025 SHALL, on err_clr without an error event, set err_cnt=0 and sel_err=0 next edge.
REQ-026 SHALL, on err_clr and error event in the same cycle, set err_cnt=1 and sel_err=1.
REQ-027 SHALL keep out_data unchanged when out_valid falls: only out_valid signals emptiness.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force out_valid=0, out_data=0, sel_err=0, err_cnt=0.
REQ-029 SHALL discard any held, unconsumed result when reset asserts mid-operation.
REQ-030 SHALL show in_ready=1 during reset and on the first edge after release.

Structure
REQ-031 SHALL take from shared package mips_mux_pkg: DATA_W_DEFAULT=32, ERR_CNT_W=8, and the select-width function clog2_min1.
REQ-032 SHALL implement channel extraction and range check as a combinational function inside the module, with no sub-module.
REQ-033 SHALL have a single output register stage: no internal FIFO beyond one entry.

Verification
REQ-034 SHALL pass: N=3, in={5,9,12}, sel=0,1,2 back-to-back, out_ready=1 -> out_data 5,9,12 on consecutive cycles, out_valid held 1.
REQ-035 SHALL pass: sel=1, then out_ready=0 for 3 cycles while in changes to {0,0,0} -> out_data stays 9, in_ready=0, then one consume -> out_valid=0.
REQ-036 SHALL pass: N=3, sel=3 accepted twice -> out_data=0 both times, sel_err=1, err_cnt=2; sel=3 with in_valid=0 -> err_cnt unchanged.
REQ-037 SHALL pass: 300 accepted sel=3 -> err_cnt=255; err_clr with sel=3 accept same cycle -> err_cnt=1, sel_err=1; err_clr alone -> 0/0.
REQ-038 SHALL pass: rst_n low mid-hold (out_valid=1, out_ready=0) -> out_valid=0, out_data=0 immediately, without waiting for a clock edge; in_ready=1.
REQ-039 SHALL pass: N=16, WIDTH=8, each channel k=k+1 -> sel k gives out_data k+1 for all k.

Source files
------------

// File: rtl/mips_mux_pkg.sv
// Shared constants and helpers for the registered channel multiplexer family.
package mips_mux_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ERR_CNT_W      = 8;

  // Select width for an n-way choice; a 1- or 2-way choice still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_mux_n.sv
// N-way channel multiplexer with a single-entry valid/ready output register
// and sticky/saturating error reporting for out-of-range selects.
module reg_mux_n
  import mips_mux_pkg::*;
#(
  parameter  int WIDTH = DATA_W_DEFAULT,
  parameter  int N     = 3,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sel_err_q, sel_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 accept, err_event;

  function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
    return int'(s) < N;
  endfunction

  // Out-of-range selects match no channel and fall through to zero.
  function automatic logic [WIDTH-1:0] pick_channel(input logic [N*WIDTH-1:0] data,
                                                    input logic [SEL_W-1:0]   s);
    logic [WIDTH-1:0] result;
    // NOTE: blocking assignments inside functions/always_comb model wires, not state.
    result = '0;
    for (int k = 0; k < N; k++) begin
      if (s == SEL_W'(k)) result = data[k*WIDTH +: WIDTH];
    end
    return result;
  endfunction

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign err_event = accept && !sel_in_range(sel);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      out_data_d  = pick_channel(in_data, sel);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (err_clr) begin
      sel_err_d = err_event;
      err_cnt_d = err_event ? ERR_CNT_W'(1) : '0;
    end else if (err_event) begin
      sel_err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: out_data is reset too, so the output is defined zero from reset onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_reg_mux_n.sv
// Self-checking bench for reg_mux_n: directed scenarios plus random traffic
// against a transaction-level reference model, on a 3-way and a 16-way instance.
module tb_reg_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 3-way, 32-bit instance
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, in_ready, out_valid, out_ready, sel_err, err_clr;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  reg_mux_n #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // 16-way, 8-bit instance
  logic [127:0] in16;
  logic [3:0]   sel16;
  logic         in_valid16, in_ready16, out_valid16, out_ready16, sel_err16, err_clr16;
  logic [7:0]   out16, err_cnt16;

  reg_mux_n #(.WIDTH(8), .N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in16), .sel(sel16), .in_valid(in_valid16),
    .in_ready(in_ready16), .out_data(out16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sel_err(sel_err16), .err_cnt(err_cnt16), .err_clr(err_clr16)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: channel values, one held result, and error bookkeeping.
  int unsigned chan [3];
  logic        m_valid;
  int unsigned m_data;
  int          m_cnt;
  logic        m_serr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int unsigned s, input logic ordy, input logic clr);
    in_valid  = v;
    sel       = s[1:0];
    out_ready = ordy;
    err_clr   = clr;
    in_data   = {chan[2], chan[1], chan[0]};
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_cnt   = 0;
    m_serr  = 1'b0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check state after.
  task automatic step();
    logic acc, bad;
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || out_ready)});
    acc = in_valid && (!m_valid || out_ready);
    bad = acc && (sel >= 2'd3);
    if (acc) begin
      m_valid = 1'b1;
      m_data  = bad ? 0 : chan[sel];
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (err_clr) begin
      m_cnt  = bad ? 1 : 0;
      m_serr = bad;
    end else if (bad) begin
      m_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_serr = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_data",  out_data, m_data);
    check("sel_err",   {31'b0, sel_err}, {31'b0, m_serr});
    check("err_cnt",   {24'b0, err_cnt}, m_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    chan  = '{5, 9, 12};
    drive(1'b0, 0, 1'b0, 1'b0);
    in16 = '0; sel16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1; err_clr16 = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_sel_err",   {31'b0, sel_err}, 32'd0);
    check("rst_err_cnt",   {24'b0, err_cnt}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back 5, 9, 12 with out_ready high; first step also covers in_ready after release
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, s, 1'b1, 1'b0);
      step();
      check("b2b_data", out_data, chan[s]);
    end

    // Hold under backpressure while inputs change, then one consume
    drive(1'b1, 1, 1'b1, 1'b0);
    step();
    chan = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      step();
      check("hold_data", out_data, 32'd9);
      check("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    step();
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_keeps_data", out_data, 32'd9);

    // Out-of-range selects: two accepted, one not offered
    chan = '{5, 9, 12};
    drive(1'b1, 3, 1'b1, 1'b0); step();
    drive(1'b1, 3, 1'b1, 1'b0); step();
    check("oor_cnt2", {24'b0, err_cnt}, 32'd2);
    check("oor_data0", out_data, 32'd0);
    drive(1'b0, 3, 1'b1, 1'b0); step();
    check("oor_ignored", {24'b0, err_cnt}, 32'd2);

    // Saturation and clear interactions
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3, 1'b1, 1'b0);
      step();
    end
    check("sat_255", {24'b0, err_cnt}, 32'd255);
    drive(1'b1, 3, 1'b1, 1'b1); step();
    check("clr_with_err", {24'b0, err_cnt}, 32'd1);
    check("clr_with_err_flag", {31'b0, sel_err}, 32'd1);
    drive(1'b0, 0, 1'b1, 1'b1); step();
    check("clr_alone", {24'b0, err_cnt}, 32'd0);
    check("clr_alone_flag", {31'b0, sel_err}, 32'd0);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      for (int k = 0; k < 3; k++) chan[k] = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      step();
    end

    // Asynchronous reset while holding a result
    drive(1'b1, 2, 1'b1, 1'b0);
    chan[2] = 32'hCAFE;
    drive(1'b1, 2, 1'b1, 1'b0);
    step();
    drive(1'b1, 1, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_data",  out_data, 32'd0);
    check("arst_ready", {31'b0, in_ready}, 32'd1);
    check("arst_cnt",   {24'b0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 0, 1'b0, 1'b0);
    step();

    // 16-way instance: channel k carries k+1
    for (int k = 0; k < 16; k++) in16[k*8 +: 8] = 8'(k + 1);
    for (int k = 0; k < 16; k++) begin
      sel16 = 4'(k);
      in_valid16 = 1'b1;
      @(posedge clk);
      #1;
      check("n16_data", {24'b0, out16}, k + 1);
      check("n16_valid", {31'b0, out_valid16}, 32'd1);
    end
    check("n16_no_err", {24'b0, err_cnt16}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
